// File: rtl/double_buffer.sv
// rtl/double_buffer.sv - front/back bank pair with swap and background clear
module double_buffer #(
  parameter int    WIDTH      = 16,
  parameter int    DEPTH      = 32,
  parameter int    AUTO_CLEAR = 0,
  parameter string FILE       = "",
  localparam int   AW         = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             write_enable,
  input  logic [AW-1:0]    addr_write,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    addr_read,
  output logic [WIDTH-1:0] data_out,
  input  logic             clear,
  input  logic [WIDTH-1:0] clear_value,
  input  logic             swap,
  output logic             ready,
  output logic             front_sel,
  output logic             write_dropped
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t           state, state_n;
  logic             swap_pending, swap_pending_n;
  logic [AW-1:0]    cnt, cnt_n;
  logic             front_n;
  logic [WIDTH-1:0] fill, fill_n;
  logic             ready_n, dropped_n;
  logic             armed;

  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;

  logic [WIDTH-1:0] bank0 [DEPTH];
  logic [WIDTH-1:0] bank1 [DEPTH];

  // Requests are only honoured once the reset release has been seen by one
  // clock edge, so a request coinciding with the first edge is ignored.
  logic wr_req, swap_req, clear_req;
  assign wr_req    = write_enable & armed & (addr_write <= LAST);
  assign swap_req  = swap & armed;
  assign clear_req = clear & armed;

  // Arm request acceptance one edge after reset release
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) armed <= 1'b0;
    else       armed <= 1'b1;
  end

  // Next-state, clear sequencing and back-bank write port selection
  always_comb begin
    state_n        = state;
    swap_pending_n = swap_pending;
    cnt_n          = cnt;
    front_n        = front_sel;
    fill_n         = fill;
    dropped_n      = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = addr_write;
    mem_data       = data_in;
    ready_n        = 1'b0;
    case (state)
      IDLE: begin
        // user write lands in the current back bank, even on a swap edge
        mem_we = wr_req;
        if (swap_req) front_n = ~front_sel;
        // a combined clear+swap clears only the new back bank, once
        if (clear_req || (swap_req && AUTO_CLEAR != 0)) begin
          state_n = CLEARING;
          cnt_n   = '0;
          fill_n  = clear_value;
        end
      end
      CLEARING: begin
        mem_we    = 1'b1;
        mem_addr  = cnt;
        mem_data  = fill;
        dropped_n = wr_req;
        if (swap_req) swap_pending_n = 1'b1;
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (swap_pending || swap_req) begin
            front_n        = ~front_sel;
            swap_pending_n = 1'b0;
            if (AUTO_CLEAR != 0) begin
              state_n = CLEARING;
              fill_n  = clear_value;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE) && !swap_pending_n;
  end

  // Control state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      swap_pending  <= 1'b0;
      cnt           <= '0;
      front_sel     <= 1'b0;
      fill          <= '0;
      ready         <= 1'b1;
      write_dropped <= 1'b0;
    end else begin
      state         <= state_n;
      swap_pending  <= swap_pending_n;
      cnt           <= cnt_n;
      front_sel     <= front_n;
      fill          <= fill_n;
      ready         <= ready_n;
      write_dropped <= dropped_n;
    end
  end

  // Single write port, always into the back bank; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (front_sel) bank0[mem_addr] <= mem_data;
      else           bank1[mem_addr] <= mem_data;
    end
  end

  // Registered front-bank read; out-of-range addresses read as zero
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 data_out <= '0;
    else if (addr_read > LAST) data_out <= '0;
    else if (front_sel)        data_out <= bank1[addr_read];
    else                       data_out <= bank0[addr_read];
  end

endmodule

// File: tb/tb_double_buffer.sv
// tb/tb_double_buffer.sv - scoreboard bench for double_buffer
`timescale 1ns/1ps
module tb_double_buffer;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  // instance A: DEPTH 20, no auto clear
  logic        a_we = 0, a_clear = 0, a_swap = 0;
  logic [4:0]  a_waddr = 0, a_raddr = 0;
  logic [15:0] a_din = 0, a_cval = 0, a_dout;
  logic        a_ready, a_front, a_drop;

  // instance B: DEPTH 8, auto clear
  logic        b_we = 0, b_clear = 0, b_swap = 0;
  logic [2:0]  b_waddr = 0, b_raddr = 0;
  logic [15:0] b_din = 0, b_cval = 0, b_dout;
  logic        b_ready, b_front, b_drop;

  double_buffer #(.WIDTH(16), .DEPTH(20), .AUTO_CLEAR(0), .FILE("")) u_a (
    .clk(clk), .rstn(rstn), .write_enable(a_we), .addr_write(a_waddr),
    .data_in(a_din), .addr_read(a_raddr), .data_out(a_dout), .clear(a_clear),
    .clear_value(a_cval), .swap(a_swap), .ready(a_ready), .front_sel(a_front),
    .write_dropped(a_drop));

  double_buffer #(.WIDTH(16), .DEPTH(8), .AUTO_CLEAR(1), .FILE("")) u_b (
    .clk(clk), .rstn(rstn), .write_enable(b_we), .addr_write(b_waddr),
    .data_in(b_din), .addr_read(b_raddr), .data_out(b_dout), .clear(b_clear),
    .clear_value(b_cval), .swap(b_swap), .ready(b_ready), .front_sel(b_front),
    .write_dropped(b_drop));

  int n_chk = 0;
  int n_fail = 0;
  int a_low = 0, b_low = 0, a_drops = 0;

  logic [15:0] qa[$], qb[$];
  int          qa_addr[$], qb_addr[$];
  logic        rd_issue_a = 0, rd_issue_b = 0;
  logic        rd_va = 0, rd_vb = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // read-valid pipeline mirrors the one-cycle read latency
  always @(posedge clk) begin
    rd_va <= rd_issue_a;
    rd_vb <= rd_issue_b;
  end

  // scoreboard monitor: compare data_out whenever a read result is due
  always @(negedge clk) begin
    if (rd_va) begin
      if (qa.size() == 0) check("a_read_underflow", 1, 0);
      else begin
        automatic logic [15:0] e = qa.pop_front();
        automatic int ad = qa_addr.pop_front();
        check($sformatf("a_read[%0d]", ad), a_dout, e);
      end
    end
    if (rd_vb) begin
      if (qb.size() == 0) check("b_read_underflow", 1, 0);
      else begin
        automatic logic [15:0] e = qb.pop_front();
        automatic int ad = qb_addr.pop_front();
        check($sformatf("b_read[%0d]", ad), b_dout, e);
      end
    end
  end

  // busy-cycle and dropped-write counters
  always @(negedge clk) begin
    if (!a_ready) a_low <= a_low + 1;
    if (!b_ready) b_low <= b_low + 1;
    if (a_drop)   a_drops <= a_drops + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int addr, input logic [15:0] d);
    a_we = 1; a_waddr = 5'(addr); a_din = d; tick(); a_we = 0;
  endtask

  task automatic wr_b(input int addr, input logic [15:0] d);
    b_we = 1; b_waddr = 3'(addr); b_din = d; tick(); b_we = 0;
  endtask

  task automatic rd_a(input int addr, input logic [15:0] e);
    a_raddr = 5'(addr); qa.push_back(e); qa_addr.push_back(addr);
    rd_issue_a = 1; tick(); rd_issue_a = 0;
  endtask

  task automatic rd_b(input int addr, input logic [15:0] e);
    b_raddr = 3'(addr); qb.push_back(e); qb_addr.push_back(addr);
    rd_issue_b = 1; tick(); rd_issue_b = 0;
  endtask

  task automatic swap_a();
    a_swap = 1; tick(); a_swap = 0;
  endtask

  task automatic swap_b();
    b_swap = 1; tick(); b_swap = 0;
  endtask

  task automatic wait_ready_a(input string name, input logic hold_front);
    automatic bit done = 0;
    automatic bit moved = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!a_ready && a_front !== hold_front) moved = 1;
      if (a_ready) done = 1;
    end
    check({name, "_ready_timeout"}, 32'(done), 1);
    check({name, "_front_held_while_busy"}, 32'(moved), 0);
  endtask

  task automatic wait_ready_b(input string name);
    automatic bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (b_ready) done = 1;
    end
    check({name, "_ready_timeout"}, 32'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dbase;
    #1 rstn = 0;
    #2;
    check("rst_a_ready", 32'(a_ready), 1);
    check("rst_a_front", 32'(a_front), 0);
    check("rst_a_drop", 32'(a_drop), 0);
    check("rst_a_dout", 32'(a_dout), 0);
    check("rst_b_ready", 32'(b_ready), 1);
    #10 rstn = 1;
    repeat (3) tick();

    // fill bank 1 (back), swap, read back through the front
    for (int i = 0; i < 20; i++) wr_a(i, (i == 3) ? 16'hA5A5 : 16'h1100 + 16'(i));
    swap_a();
    @(negedge clk);
    check("swap1_front", 32'(a_front), 1);
    check("swap1_ready", 32'(a_ready), 1);
    rd_a(3, 16'hA5A5);
    rd_a(0, 16'h1100);
    rd_a(20, 16'h0000);
    rd_a(31, 16'h0000);

    // fill bank 0, out-of-range write is silently discarded
    for (int i = 0; i < 20; i++) wr_a(i, 16'h2200 + 16'(i));
    wr_a(25, 16'hDEAD);
    swap_a();
    @(negedge clk);
    check("swap2_front", 32'(a_front), 0);
    rd_a(5, 16'h2205);
    rd_a(19, 16'h2213);

    // clear back bank 1 with 0x00FF; dropped write, ignored clear and value change
    base = a_low; dbase = a_drops;
    a_cval = 16'h00FF; a_clear = 1; tick(); a_clear = 0; a_cval = 16'h1234;
    rd_a(7, 16'h2207);
    a_we = 1; a_waddr = 0; a_din = 16'hBEEF; a_clear = 1; tick(); a_we = 0; a_clear = 0;
    wait_ready_a("clr1", 1'b0);
    check("clr1_busy_cycles", 32'(a_low - base), 20);
    check("clr1_drop_pulses", 32'(a_drops - dbase), 1);
    check("clr1_front", 32'(a_front), 0);
    rd_a(0, 16'h2200);
    rd_a(19, 16'h2213);
    swap_a();
    @(negedge clk);
    check("swap3_front", 32'(a_front), 1);
    for (int i = 0; i < 20; i++) rd_a(i, 16'h00FF);

    // swap requested on cycle 5 of a clear takes effect at completion
    base = a_low;
    a_cval = 16'h0F0F; a_clear = 1; tick(); a_clear = 0;
    repeat (4) tick();
    swap_a();
    @(negedge clk);
    check("pend_ready_low", 32'(a_ready), 0);
    check("pend_front_held", 32'(a_front), 1);
    wait_ready_a("clr2", 1'b1);
    check("clr2_front_toggled", 32'(a_front), 0);
    check("clr2_busy_cycles", 32'(a_low - base), 20);
    rd_a(0, 16'h0F0F);
    rd_a(19, 16'h0F0F);

    // reset after ten clear writes; partial clear retained
    swap_a();
    @(negedge clk);
    check("swap4_front", 32'(a_front), 1);
    a_raddr = 19;
    a_cval = 16'h3C3C; a_clear = 1; tick(); a_clear = 0;
    repeat (10) tick();
    rstn = 0;
    #1;
    check("midrst_ready", 32'(a_ready), 1);
    check("midrst_front", 32'(a_front), 0);
    check("midrst_dout", 32'(a_dout), 0);
    repeat (2) tick();
    // a request on the first edge after release is ignored
    rstn = 1; a_swap = 1; tick(); a_swap = 0;
    @(negedge clk);
    check("release_first_edge_ignored", 32'(a_front), 0);
    repeat (2) tick();
    for (int i = 0; i < 20; i++) rd_a(i, (i < 10) ? 16'h3C3C : 16'h0F0F);

    // auto clear: clear+swap together gives one DEPTH-cycle clear
    for (int i = 0; i < 8; i++) wr_b(i, 16'h7700 + 16'(i));
    base = b_low;
    b_cval = 16'h5555; b_clear = 1; b_swap = 1; tick(); b_clear = 0; b_swap = 0;
    b_cval = 16'h9999;
    @(negedge clk);
    check("b_cs_front", 32'(b_front), 1);
    check("b_cs_ready", 32'(b_ready), 0);
    wait_ready_b("b_cs");
    check("b_cs_busy_cycles", 32'(b_low - base), 8);
    for (int i = 0; i < 8; i++) rd_b(i, 16'h7700 + 16'(i));

    base = b_low;
    b_cval = 16'h6666; swap_b();
    wait_ready_b("b_sw1");
    check("b_sw1_busy_cycles", 32'(b_low - base), 8);
    check("b_sw1_front", 32'(b_front), 0);
    for (int i = 0; i < 8; i++) rd_b(i, 16'h5555);

    swap_b();
    wait_ready_b("b_sw2");
    check("b_sw2_front", 32'(b_front), 1);
    for (int i = 0; i < 8; i++) rd_b(i, 16'h6666);

    repeat (3) tick();
    check("a_queue_drained", 32'(qa.size()), 0);
    check("b_queue_drained", 32'(qb.size()), 0);
    check("a_total_drops", 32'(a_drops), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
